// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 definitions.
//   - HASH_INIT0..7: standard initial hash words.
//     sha256_main_calhash uses the same constants.
//   - K_TAB / k_val(): the 64 round constants.
//   - state_t: compression FSM states.
//   - work_t: working variables a..h, with a in the most significant word.
//   - Σ0, Σ1, σ0, σ1, Ch and Maj helper functions.
package sha256_pkg;

  localparam logic [31:0] HASH_INIT0 = 32'h6a09e667;
  localparam logic [31:0] HASH_INIT1 = 32'hbb67ae85;
  localparam logic [31:0] HASH_INIT2 = 32'h3c6ef372;
  localparam logic [31:0] HASH_INIT3 = 32'ha54ff53a;
  localparam logic [31:0] HASH_INIT4 = 32'h510e527f;
  localparam logic [31:0] HASH_INIT5 = 32'h9b05688c;
  localparam logic [31:0] HASH_INIT6 = 32'h1f83d9ab;
  localparam logic [31:0] HASH_INIT7 = 32'h5be0cd19;

  localparam logic [255:0] HASH_INIT_ALL = {HASH_INIT0, HASH_INIT1, HASH_INIT2, HASH_INIT3,
                                            HASH_INIT4, HASH_INIT5, HASH_INIT6, HASH_INIT7};

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  function automatic logic [31:0] k_val(input logic [5:0] t);
    return K_TAB[t];
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Σ0 and Σ1 mix the working variables.
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  // σ0 and σ1 mix the message schedule.
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_regx.sv
// sha256_regx: enable register with an asynchronous active-low reset.
//   clk     : system clock, rising edge
//   reset_n : asynchronous reset; loads RST_VAL
//   en      : q loads d at the clock edge when en is high
//   d       : next value
//   q       : registered value
module sha256_regx #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sha256_round.sv
// sha256_round: one SHA-256 compression round. This module is purely
// combinational.
//   st_i : working variables a..h before the round
//   kt_i : round constant K[t]
//   wt_i : message schedule word W[t]
//   st_o : working variables a..h after the round
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       st_i,
  input  logic [31:0] kt_i,
  input  logic [31:0] wt_i,
  output work_t       st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = st_i.h + bsig1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + kt_i + wt_i;
  assign t2 = bsig0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);

  assign st_o.a = t1 + t2;
  assign st_o.b = st_i.a;
  assign st_o.c = st_i.b;
  assign st_o.d = st_i.c;
  assign st_o.e = st_i.d + t1;
  assign st_o.f = st_i.e;
  assign st_o.g = st_i.f;
  assign st_o.h = st_i.g;

endmodule

// File: rtl/sha256_main_compress.sv
// sha256_main_compress: iterative SHA-256 compression of one 512-bit block.
// Every start reloads a..h from HASH_INIT0..7, so each block is hashed on
// its own.
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : begin a block; sampled only in IDLE
//   block      : padded block, [511:480]=W0 .. [31:0]=W15
//   busy       : high in ROUND and DONE
//   a..h       : working variables, registered
//   hash_en    : one-cycle strobe; a..h hold the final round values
//   dbg_state  : current FSM state, for debug and checkers
//
// Handshake: start acts as a request, and the engine accepts it only when busy
// is low (IDLE). A start raised while busy is ignored, and block is not
// sampled. If start stays high, one block is accepted every ROUNDS+2 cycles.
//
// Build option SHA256_COMPRESS_UNROLL2_EN chains two rounds per clock.
// ROUND then lasts ROUNDS/2 cycles, so ROUNDS must be even. The final a..h
// values are the same in both builds.
module sha256_main_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] block,
  output logic         busy,
  output logic [31:0]  a,
  output logic [31:0]  b,
  output logic [31:0]  c,
  output logic [31:0]  d,
  output logic [31:0]  e,
  output logic [31:0]  f,
  output logic [31:0]  g,
  output logic [31:0]  h,
  output logic         hash_en,
  output logic [1:0]   dbg_state
);

`ifdef SHA256_COMPRESS_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  // t value during the last ROUND cycle.
  localparam logic [6:0] LAST_T = 7'(ROUNDS - STEP);

  state_t             state_q, state_d;
  logic [6:0]         t_q, t_d;
  work_t              work_q, work_d;
  logic               work_en;
  // W window: win_q[0] is W[t], the word consumed this cycle.
  logic [15:0][31:0]  win_q, win_d;
  logic               win_en;
  work_t              rnd0_out;
  work_t              rnd_out;
  logic [31:0]        new_w0;

  // Next schedule word: W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t].
  assign new_w0 = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  sha256_round u_round0 (
    .st_i (work_q),
    .kt_i (k_val(t_q[5:0])),
    .wt_i (win_q[0]),
    .st_o (rnd0_out)
  );

`ifdef SHA256_COMPRESS_UNROLL2_EN
  logic [31:0] new_w1;

  // W[t+17] uses only words that are already in the window.
  assign new_w1 = ssig1(win_q[15]) + win_q[10] + ssig0(win_q[2]) + win_q[1];

  sha256_round u_round1 (
    .st_i (rnd0_out),
    .kt_i (k_val(t_q[5:0] + 6'd1)),
    .wt_i (win_q[1]),
    .st_o (rnd_out)
  );
`else
  assign rnd_out = rnd0_out;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_en = 1'b0;
    work_d  = work_q;
    win_en  = 1'b0;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROUND;
          t_d     = '0;
          work_en = 1'b1;
          work_d  = work_t'(HASH_INIT_ALL);
          win_en  = 1'b1;
          for (int i = 0; i < 16; i++) begin
            win_d[i] = block[511 - 32*i -: 32];
          end
        end
      end
      ROUND: begin
        work_en = 1'b1;
        work_d  = rnd_out;
        win_en  = 1'b1;
`ifdef SHA256_COMPRESS_UNROLL2_EN
        for (int i = 0; i < 14; i++) begin
          win_d[i] = win_q[i+2];
        end
        win_d[14] = new_w0;
        win_d[15] = new_w1;
`else
        for (int i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = new_w0;
`endif
        if (t_q == LAST_T) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 7'(STEP);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  sha256_regx #(.W(256), .RST_VAL(HASH_INIT_ALL)) u_work_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (work_en),
    .d       (work_d),
    .q       (work_q)
  );

  sha256_regx #(.W(512), .RST_VAL('0)) u_win_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (win_en),
    .d       (win_d),
    .q       (win_q)
  );

  // Both status outputs decode the state flop directly, so they are glitch-free.
  assign busy      = (state_q != IDLE);
  assign hash_en   = (state_q == DONE);
  assign dbg_state = state_q;

  assign a = work_q.a;
  assign b = work_q.b;
  assign c = work_q.c;
  assign d = work_q.d;
  assign e = work_q.e;
  assign f = work_q.f;
  assign g = work_q.g;
  assign h = work_q.h;

endmodule

// File: tb/tb_sha256_main_compress.sv
// tb_sha256_main_compress: directed-vector bench for sha256_main_compress.
// Expected values are the published SHA-256 results for "abc" and for the
// empty message. The bench checks the final working variables and the
// digest words formed by adding the initial hash values.
module tb_sha256_main_compress;

`ifdef SHA256_COMPRESS_UNROLL2_EN
  localparam int RND_CYC = 32;
`else
  localparam int RND_CYC = 64;
`endif
  localparam int LAT     = RND_CYC + 1;
  localparam int BLK_CYC = RND_CYC + 2;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};

  localparam logic [255:0] INIT_ALL = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_FINAL = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
  localparam logic [255:0] EMPTY_FINAL = {32'h79a6dddb, 32'hdd946d8f, 32'h5e8d0156, 32'hf41fc3ea,
                                          32'hd69fef65, 32'hc9962ac0, 32'h8511bf70, 32'h1c71eb3c};

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [511:0] block;
  logic         busy;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic         hash_en;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hash_cnt = 0;
  logic [255:0] exp_q[$];

  sha256_main_compress #(.ROUNDS(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .block     (block),
    .busy      (busy),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .hash_en   (hash_en),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each hash_en pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (reset_n && hash_en) begin
      hash_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_hash_en", 256'(hash_en), 256'(0));
      end else begin
        check("final_a_to_h", {a, b, c, d, e, f, g, h}, exp_q.pop_front());
      end
    end
  end

  // Driver: pulse start for one edge and return the index of the accepting edge.
  task automatic start_block(input logic [511:0] blk, output int e0);
    @(negedge clk);
    start = 1'b1;
    block = blk;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  // Wait, with a cycle budget, for hash_en. Returns the index of the last posedge.
  task automatic wait_hash(input int budget, output int hcyc);
    int n;
    n = 0;
    while (hash_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("hash_en_seen", 256'(hash_en), 256'(1));
    hcyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, h1, h2, h3;
    reset_n = 1'b0;
    start   = 1'b0;
    block   = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_a_to_h", {a, b, c, d, e, f, g, h}, INIT_ALL);
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_hash_en", 256'(hash_en), 256'(0));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_hold_a_to_h", {a, b, c, d, e, f, g, h}, INIT_ALL);
    check("idle_busy", 256'(busy), 256'(0));

    // "abc" block: first-edge values, final values and digest words.
    exp_q.push_back(ABC_FINAL);
    start_block(ABC_BLK, e0);
    @(posedge clk);
    @(negedge clk);
`ifdef SHA256_COMPRESS_UNROLL2_EN
    check("abc_e1_a", 256'(a), 256'(32'h5a6ad9ad));
    check("abc_e1_e", 256'(e), 256'(32'h78ce7989));
`else
    check("abc_e1_a", 256'(a), 256'(32'h5d6aebcd));
    check("abc_e1_e", 256'(e), 256'(32'hfa2a4622));
`endif
    check("abc_busy", 256'(busy), 256'(1));
    wait_hash(100, h1);
    check("abc_latency", 256'(h1 + 1 - e0), 256'(LAT));
    check("abc_digest_w0", 256'(a + 32'h6a09e667), 256'(32'hba7816bf));
    check("abc_digest_w7", 256'(h + 32'h5be0cd19), 256'(32'hf20015ad));
    @(negedge clk);
    check("hash_en_one_cycle", 256'(hash_en), 256'(0));
    @(negedge clk);
    check("abc_hold_after_done", {a, b, c, d, e, f, g, h}, ABC_FINAL);
    check("abc_idle_busy", 256'(busy), 256'(0));

    // Empty-message block.
    exp_q.push_back(EMPTY_FINAL);
    start_block(EMPTY_BLK, e0);
    wait_hash(100, h1);
    check("empty_digest_w0", 256'(a + 32'h6a09e667), 256'(32'he3b0c442));

    // A start raised during ROUND is ignored.
    exp_q.push_back(ABC_FINAL);
    start_block(ABC_BLK, e0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    block = EMPTY_BLK;
    @(negedge clk);
    start = 1'b0;
    wait_hash(100, h1);
    check("ignored_start_latency", 256'(h1 + 1 - e0), 256'(LAT));
    repeat (3) @(negedge clk);
    check("ignored_start_idle", 256'(busy), 256'(0));

    // Reset during ROUND aborts the block without a hash_en pulse.
    start_block(EMPTY_BLK, e0);
    repeat (RND_CYC / 2 - 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_a_to_h", {a, b, c, d, e, f, g, h}, INIT_ALL);
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_hash_en", 256'(hash_en), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (RND_CYC + 10) @(negedge clk);
    check("abort_no_hash", 256'(hash_cnt), 256'(3));
    exp_q.push_back(ABC_FINAL);
    start_block(ABC_BLK, e0);
    wait_hash(100, h1);
    check("post_abort_latency", 256'(h1 + 1 - e0), 256'(LAT));

    // Back-to-back blocks with start held high.
    repeat (3) exp_q.push_back(ABC_FINAL);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    block = ABC_BLK;
    wait_hash(100, h1);
    @(negedge clk);
    wait_hash(100, h2);
    check("b2b_interval_1", 256'(h2 - h1), 256'(BLK_CYC));
    @(negedge clk);
    wait_hash(100, h3);
    start = 1'b0;
    check("b2b_interval_2", 256'(h3 - h2), 256'(BLK_CYC));
    repeat (5) @(negedge clk);
    check("b2b_idle_busy", 256'(busy), 256'(0));

    check("hash_count", 256'(hash_cnt), 256'(7));
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_main_compress.md
Name: sha256_main_compress

Overview:
- Iterative SHA-256 compression engine for one 512-bit padded message block.
- Computes the message schedule W[0..63] on the fly and runs 64 rounds, one per clock.
- Drives working variables a..h and a one-cycle hash_en strobe directly into sha256_main_calhash, which adds the standard initial hash values and registers the 256-bit digest.
- Single-block only: working variables are initialised from HASH_INIT0..7 at every start.

Parameters:
- ROUNDS, 64, number of compression rounds. Fixed at 64 for SHA-256; values other than 64 are for reduced-round debug only.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin compression of block; sampled only in IDLE
- block  input  512  padded message block; [511:480]=W0 … [31:0]=W15; sampled on the accepted start edge only
- busy  output  1  high in ROUND and DONE
- a,b,c,d,e,f,g,h  output  32 each  working variables, registered
- hash_en  output  1  one-cycle strobe: a..h hold final round values

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, round counter t=0, busy=0, hash_en=0.
  - a..h = HASH_INIT0..7 (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - W window = 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - start=1 at a clock edge: load a..h=HASH_INIT0..7, load 16-word W window from block, set t=0, go to ROUND.
  - start=0: a..h hold.
- ROUND, each edge, with all additions mod 2^32:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt; T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Wt is window[0] for every t, including t<16.
  - Window shifts by one word; the new word is σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - t increments by 1.
  - Edge with t=ROUNDS-1: go to DONE; t wraps to 0.
- DONE:
  - hash_en=1 for exactly one cycle; a..h stable.
  - Next edge: go to IDLE.
- Latency: start sampled at edge E0; rounds at edges E1..E64; hash_en high during the cycle after E64. sha256_main_calhash captures at edge E65.
- Outputs after DONE: a..h hold the final values until the next accepted start.
- Throughput: a new start is accepted the cycle after DONE. Cycles per block = ROUNDS+2.
- start while busy=1: ignored; block is not re-sampled.
- start held high continuously: back-to-back blocks, one accepted per ROUNDS+2 cycles.
- reset_n asserted mid-ROUND: immediate abort to reset values; no hash_en.
- hash_en is registered (decoded from the state register), glitch-free.

Optional Feature:
- Macro: SHA256_COMPRESS_UNROLL2_EN.
- Defined:
  - Two rounds are chained combinationally per clock; t steps by 2; the window shifts 2 words per cycle.
  - ROUND lasts ROUNDS/2 cycles; hash_en is high during the cycle after E32.
  - ROUNDS must be even.
- Undefined: one round per clock, as above.
- Final a..h values are identical in both builds.

Decomposition:
- Package sha256_pkg:
  - HASH_INIT0..7 constants, shared with sha256_main_calhash.
  - 64-entry K constant table, or a function returning K[t].
  - FSM state typedef {IDLE, ROUND, DONE}.
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
- Sub-module sha256_round: purely combinational, one round.
  - Inputs: a..h, Kt, Wt. Outputs: next a..h.
  - Instantiated once, or twice under SHA256_COMPRESS_UNROLL2_EN.
- Message schedule window and FSM stay in sha256_main_compress.
- Sequential elements use sha256_regx where an enable-register fits.

Test Plan:
- Reset: hold reset_n=0 → a..h=HASH_INIT0..7, busy=0, hash_en=0. Release; no start → values held.
- "abc" block (61626380, 0×14, 00000018):
  - After E1: a=5d6aebcd, e=fa2a4622.
  - At hash_en: a..h = 506e3058 d39a2165 04d24d6c b85e2ce9 5ef50f24 fb121210 948d25b6 961f4894.
  - With calhash attached: digest ba7816bf…f20015ad.
- Empty-message block (80000000, 0×15): at hash_en, a=79a6dddb; calhash hash_val[255:224]=e3b0c442.
- start pulsed at round 10 with a different block → ignored; "abc" final values unchanged. hash_en occurs exactly once, 65 cycles after the original start edge.
- reset_n pulsed low at round 30 → outputs return to reset values asynchronously, no hash_en. A subsequent "abc" start gives the correct result.
- start held high for 3 blocks → hash_en every 66 cycles. Under SHA256_COMPRESS_UNROLL2_EN: every 34 cycles with identical a..h.
